// File: rtl/function_sweep_ctrl.sv
// Sequences the 3-bit vector space through three implementations of Y = ~A&C | B&C,
// compares each against a golden truth table and accumulates per-vector mismatch results.
module function_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECTED      = 8'h8A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       y_sop,
   input  logic       y_pos,
   input  logic       y_kmap,
   output logic [2:0] abc,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] mism_sop,
   output logic [7:0] mism_pos,
   output logic [7:0] mism_kmap,
   output logic [4:0] err_count
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] LAST_WAIT = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] waitCnt;
   logic       expBit;
   logic       missSop;
   logic       missPos;
   logic       missKmap;
   logic [4:0] missSum;

   always_comb begin
      expBit   = EXPECTED[abc];
      missSop  = y_sop ^ expBit;
      missPos  = y_pos ^ expBit;
      missKmap = y_kmap ^ expBit;
      missSum  = {4'b0, missSop} + {4'b0, missPos} + {4'b0, missKmap};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         waitCnt   <= '0;
         abc       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         mism_sop  <= '0;
         mism_pos  <= '0;
         mism_kmap <= '0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         // Abort outranks every state action; partial results stay visible.
         if (abort && (state != IDLE)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            abc     <= '0;
            pass    <= 1'b0;
            waitCnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state     <= SETTLE;
                     busy      <= 1'b1;
                     abc       <= '0;
                     waitCnt   <= '0;
                     pass      <= 1'b0;
                     mism_sop  <= '0;
                     mism_pos  <= '0;
                     mism_kmap <= '0;
                     err_count <= '0;
                  end
               end
               SETTLE: begin
                  waitCnt <= waitCnt + 4'd1;
                  if (waitCnt == LAST_WAIT) state <= SAMPLE;
               end
               SAMPLE: begin
                  if (missSop)  mism_sop[abc]  <= 1'b1;
                  if (missPos)  mism_pos[abc]  <= 1'b1;
                  if (missKmap) mism_kmap[abc] <= 1'b1;
                  err_count <= err_count + missSum;
                  if (abc != 3'd7) begin
                     abc     <= abc + 3'd1;
                     waitCnt <= '0;
                     state   <= SETTLE;
                  end else begin
                     state <= DONE;
                  end
               end
               DONE: begin
                  done  <= 1'b1;
                  pass  <= (err_count == 5'd0);
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/function_sweep_ctrl.md
FUNCTION_SWEEP_CTRL -- requirements
Module: function_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15: cycles each vector is held before sampling.
REQ-002 SHALL have parameter EXPECTED, default 8'h8A: golden truth table, bit i = Y for {A,B,C}=i (Y = ~A&C | B&C).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: request one full sweep, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1: cancel a sweep in progress.
REQ-007 SHALL have ports y_sop, y_pos, y_kmap, input, 1 each: outputs of the three implementations under sequencing.
REQ-008 SHALL have port abc, output, 3: vector driven to all three implementations; abc[2]=A, abc[1]=B, abc[0]=C.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: single-cycle pulse at sweep completion.
REQ-011 SHALL have port pass, output, 1: last completed sweep had zero mismatches.
REQ-012 SHALL have ports mism_sop, mism_pos, mism_kmap, output, 8 each: bit i set if that input differed from EXPECTED[i] at vector i.
REQ-013 SHALL have port err_count, output, 5: total mismatches across all three inputs, 0..24.

Function
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-015 IDLE with start=1 and abort=0 SHALL: abc<=0, clear all mism_* and err_count, pass<=0, wait counter<=0, go SETTLE.
REQ-016 start SHALL be ignored outside IDLE; start held high SHALL launch a new sweep on each return to IDLE.
REQ-017 SETTLE SHALL increment the wait counter each cycle and go SAMPLE when counter == SETTLE_CYCLES-1; abc stable throughout.
REQ-018 SAMPLE SHALL, for each y_x, set mism_x[abc] if y_x != EXPECTED[abc], and add the number of mismatching inputs (0..3) to err_count, in one cycle.
REQ-019 SAMPLE with abc<7 SHALL set abc<=abc+1, counter<=0, go SETTLE; with abc==7 SHALL go DONE with abc held at 7.
REQ-020 DONE SHALL assert done for exactly one cycle, set pass<=(err_count==0) using the final count including vector 7, and go IDLE.
REQ-021 Sweep latency: done SHALL be high exactly 8*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (25 for default).
REQ-022 abort=1 in SETTLE, SAMPLE or DONE SHALL force IDLE next cycle with abc<=0 and pass<=0, with no done pulse; mism_*/err_count keep their partial values and are not updated in that cycle.
REQ-023 abort and start both high in IDLE SHALL keep the block in IDLE; abort has priority.
REQ-024 mism_*, err_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-025 err_count SHALL NOT wrap; max reachable is 24, within 5 bits.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, abc=0, busy=0, done=0, pass=0, mism_*=0, err_count=0, wait counter=0.
REQ-027 After rst_n deasserts, first start SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-028 All y_* driven by EXPECTED model, start pulse, defaults -> abc steps 0..7 holding 3 cycles each; done at cycle 25; pass=1, err_count=0, mism_*=0.
REQ-029 y_sop model table 8'h88, others correct -> mism_sop=8'h02, others 0, err_count=1, pass=0.
REQ-030 All y_* stuck at 0 -> each mism_*=8'h8A, err_count=9, pass=0; stuck at 1 -> each mism_*=8'h75, err_count=15.
REQ-031 abort during vector 4 -> busy=0 and abc=0 next cycle, no done pulse, pass=0, mism_* hold only bits 0..3 results.
REQ-032 rst_n low mid-sweep (vector 5, SETTLE) -> all outputs zero immediately, without a clock edge; new start after release gives a clean 25-cycle sweep.
REQ-033 start pulsed while busy, then start held high across two sweeps -> mid-sweep start ignored; second sweep clears results and repeats REQ-028 timing.
